// File: rtl/fcmp_seq.sv
// Single-precision compare sequencer (FEQ.S / FLT.S / FLE.S): fetches both
// operands through one FP register-file read port, drives the Feq unit and hands back a 0/1 result.
module fcmp_seq #(
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [RF_AW-1:0] cmd_rs1,
  input  logic [RF_AW-1:0] cmd_rs2,
  input  logic [RF_AW-1:0] cmd_rd,
  output logic             frf_ren,
  output logic [RF_AW-1:0] frf_raddr,
  input  logic [31:0]      frf_rdata,
  output logic [31:0]      read_data1,
  output logic [31:0]      read_data2,
  output logic             Feq_en,
  input  logic [31:0]      eqdata_out,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [RF_AW-1:0] wb_rd,
  output logic [31:0]      wb_data,
  output logic             fflags_nv,
  output logic             illegal
);

  typedef enum logic [2:0] {IDLE, RD1, RD2, CMP, WB} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [RF_AW-1:0] rs2_q, rs2_d, rd_q, rd_d;
  logic [31:0]      opa_q, opa_d, opb_q, opb_d;
  logic             res_q, res_d, nv_q, nv_d, ill_q, ill_d;

  logic a_nan, b_nan, a_snan, b_snan, a_zero, b_zero, both_zero;
  logic any_nan, any_snan, eq, lt;
  logic unused_eq_bits;

  assign unused_eq_bits = ^eqdata_out[31:1];

  assign a_nan     = (&opa_q[30:23]) && (|opa_q[22:0]);
  assign b_nan     = (&opb_q[30:23]) && (|opb_q[22:0]);
  assign a_snan    = a_nan && !opa_q[22];
  assign b_snan    = b_nan && !opb_q[22];
  assign a_zero    = ~|opa_q[30:0];
  assign b_zero    = ~|opb_q[30:0];
  assign both_zero = a_zero && b_zero;
  assign any_nan   = a_nan || b_nan;
  assign any_snan  = a_snan || b_snan;
  assign eq        = both_zero || eqdata_out[0];

  // Sign-magnitude ordering; +0 and -0 compare equal.
  always_comb begin
    lt = 1'b0;
    if (both_zero)                  lt = 1'b0;
    else if (opa_q[31] != opb_q[31]) lt = opa_q[31];
    else if (!opa_q[31])            lt = opa_q[30:0] < opb_q[30:0];
    else                            lt = opa_q[30:0] > opb_q[30:0];
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    nv_d      = nv_q;
    ill_d     = ill_q;
    frf_ren   = 1'b0;
    frf_raddr = '0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          rs2_d = cmd_rs2;
          rd_d  = cmd_rd;
          if (cmd_op == 2'b11) begin
            res_d   = 1'b0;
            nv_d    = 1'b0;
            ill_d   = 1'b1;
            state_d = WB;
          end else begin
            ill_d     = 1'b0;
            frf_ren   = 1'b1;
            frf_raddr = cmd_rs1;
            state_d   = RD1;
          end
        end
      end
      RD1: begin
        opa_d     = frf_rdata;
        frf_ren   = 1'b1;
        frf_raddr = rs2_q;
        state_d   = RD2;
      end
      RD2: begin
        opb_d   = frf_rdata;
        state_d = CMP;
      end
      CMP: begin
        unique case (op_q)
          2'b00:   begin res_d = !any_nan && eq;        nv_d = any_snan; end
          2'b01:   begin res_d = !any_nan && lt;        nv_d = any_nan;  end
          default: begin res_d = !any_nan && (lt || eq); nv_d = any_nan;  end
        endcase
        state_d = WB;
      end
      WB: begin
        if (wb_ready) begin
          ill_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= 1'b0;
      nv_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      nv_q    <= nv_d;
      ill_q   <= ill_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign wb_valid   = (state_q == WB);
  assign Feq_en     = (state_q == CMP);
  assign read_data1 = opa_q;
  assign read_data2 = opb_q;
  assign wb_rd      = rd_q;
  assign wb_data    = {31'b0, res_q};
  assign fflags_nv  = nv_q;
  assign illegal    = ill_q;

endmodule

// File: tb/tb_fcmp_seq.sv
// Directed bench for fcmp_seq: register-file and bitwise-equality Feq models,
// hand-computed results for each compare, backpressure and reset cases.
module tb_fcmp_seq;

  localparam int RF_AW = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [RF_AW-1:0] cmd_rs1, cmd_rs2, cmd_rd;
  logic             frf_ren;
  logic [RF_AW-1:0] frf_raddr;
  logic [31:0]      frf_rdata;
  logic [31:0]      read_data1, read_data2;
  logic             Feq_en;
  logic [31:0]      eqdata_out;
  logic             wb_valid;
  logic             wb_ready;
  logic [RF_AW-1:0] wb_rd;
  logic [31:0]      wb_data;
  logic             fflags_nv;
  logic             illegal;

  logic [31:0] mem [32];
  int n_assert = 0;
  int n_fail   = 0;

  fcmp_seq #(.RF_AW(RF_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .frf_ren(frf_ren), .frf_raddr(frf_raddr), .frf_rdata(frf_rdata),
    .read_data1(read_data1), .read_data2(read_data2),
    .Feq_en(Feq_en), .eqdata_out(eqdata_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .fflags_nv(fflags_nv), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frf_ren) frf_rdata <= mem[frf_raddr];

  // Feq model: raw bit equality, so +0 vs -0 returns 0.
  assign eqdata_out = {31'b0, (read_data1 == read_data2)};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic exp_d,
                        input logic exp_nv);
    int cyc, feq_cnt, ren_cnt;
    logic is_ill;
    is_ill  = (op == 2'b11);
    feq_cnt = 0;
    ren_cnt = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_rs1 = r1; cmd_rs2 = r2; cmd_rd = rd;
    #0;
    chk({tag, ".ready"}, {31'b0, cmd_ready}, 32'd1);
    chk({tag, ".ren0"}, {31'b0, frf_ren}, {31'b0, !is_ill});
    if (!is_ill) chk({tag, ".raddr0"}, {27'b0, frf_raddr}, {27'b0, r1});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 1;
    while (!wb_valid && cyc < 20) begin
      feq_cnt += int'(Feq_en);
      ren_cnt += int'(frf_ren);
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, cyc, is_ill ? 32'd1 : 32'd4);
    chk({tag, ".feq_cycles"}, feq_cnt, is_ill ? 32'd0 : 32'd1);
    chk({tag, ".ren_cycles"}, ren_cnt, is_ill ? 32'd0 : 32'd1);
    chk({tag, ".data"}, wb_data, {31'b0, exp_d});
    chk({tag, ".nv"}, {31'b0, fflags_nv}, {31'b0, exp_nv});
    chk({tag, ".illegal"}, {31'b0, illegal}, {31'b0, is_ill});
    chk({tag, ".rd"}, {27'b0, wb_rd}, {27'b0, rd});
    chk({tag, ".feq_wb"}, {31'b0, Feq_en}, 32'd0);
    if (!is_ill) begin
      chk({tag, ".opA"}, read_data1, mem[r1]);
      chk({tag, ".opB"}, read_data2, mem[r2]);
    end
    @(posedge clk); #1;
    chk({tag, ".idle_ready"}, {31'b0, cmd_ready}, 32'd1);
    chk({tag, ".idle_valid"}, {31'b0, wb_valid}, 32'd0);
    chk({tag, ".idle_ill"}, {31'b0, illegal}, 32'd0);
  endtask

  initial begin
    int cyc;
    int wbv_seen;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[1]  = 32'h40200000;  // 2.5
    mem[2]  = 32'hC1433333;  // -12.2
    mem[3]  = 32'h41600000;  // 14
    mem[4]  = 32'h42E00000;  // 112
    mem[5]  = 32'h42F00000;  // 120
    mem[6]  = 32'h00000000;  // +0
    mem[7]  = 32'h80000000;  // -0
    mem[8]  = 32'h7FC00000;  // qNaN
    mem[9]  = 32'h3F800000;  // 1.0
    mem[10] = 32'h7FA00000;  // sNaN
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
    wb_ready = 1'b1;
    #1;
    chk("rst.wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst.feq_en", {31'b0, Feq_en}, 32'd0);
    chk("rst.frf_ren", {31'b0, frf_ren}, 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.illegal", {31'b0, illegal}, 32'd0);
    chk("rst.rd1", read_data1, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst.cmd_ready", {31'b0, cmd_ready}, 32'd1);

    do_cmd("feq_eq",      2'b00, 5'd1, 5'd1, 5'd3,  1'b1, 1'b0);
    do_cmd("flt_neg_pos", 2'b01, 5'd2, 5'd3, 5'd4,  1'b1, 1'b0);
    do_cmd("fle_lt",      2'b10, 5'd4, 5'd5, 5'd5,  1'b1, 1'b0);
    do_cmd("flt_gt",      2'b01, 5'd5, 5'd4, 5'd6,  1'b0, 1'b0);
    do_cmd("flt_negneg",  2'b01, 5'd2, 5'd7, 5'd7,  1'b1, 1'b0);
    do_cmd("fle_eq",      2'b10, 5'd9, 5'd9, 5'd8,  1'b1, 1'b0);
    do_cmd("feq_pz_nz",   2'b00, 5'd6, 5'd7, 5'd9,  1'b1, 1'b0);
    do_cmd("flt_pz_nz",   2'b01, 5'd6, 5'd7, 5'd10, 1'b0, 1'b0);
    do_cmd("fle_pz_nz",   2'b10, 5'd6, 5'd7, 5'd11, 1'b1, 1'b0);
    do_cmd("flt_qnan",    2'b01, 5'd8, 5'd9, 5'd12, 1'b0, 1'b1);
    do_cmd("feq_qnan",    2'b00, 5'd8, 5'd9, 5'd13, 1'b0, 1'b0);
    do_cmd("feq_snan",    2'b00, 5'd10, 5'd9, 5'd14, 1'b0, 1'b1);
    do_cmd("fle_qnan",    2'b10, 5'd9, 5'd8, 5'd15, 1'b0, 1'b1);
    do_cmd("illegal",     2'b11, 5'd1, 5'd2, 5'd16, 1'b0, 1'b0);

    // Backpressure: WB holds while new commands are offered and ignored.
    wb_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_rs1 = 5'd2; cmd_rs2 = 5'd3; cmd_rd = 5'd20;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 1;
    while (!wb_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("bp.latency", cyc, 32'd4);
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rs1 = 5'd1; cmd_rs2 = 5'd1; cmd_rd = 5'd21;
      #0;
      chk("bp.valid", {31'b0, wb_valid}, 32'd1);
      chk("bp.ready", {31'b0, cmd_ready}, 32'd0);
      chk("bp.data", wb_data, 32'd1);
      chk("bp.rd", {27'b0, wb_rd}, 32'd20);
      chk("bp.nv", {31'b0, fflags_nv}, 32'd0);
      chk("bp.ren", {31'b0, frf_ren}, 32'd0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("bp.still_valid", {31'b0, wb_valid}, 32'd1);
    chk("bp.still_rd", {27'b0, wb_rd}, 32'd20);
    wb_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.released_valid", {31'b0, wb_valid}, 32'd0);
    chk("bp.released_ready", {31'b0, cmd_ready}, 32'd1);
    do_cmd("bp.next", 2'b00, 5'd1, 5'd1, 5'd21, 1'b1, 1'b0);

    // Reset asserted while in CMP.
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rs1 = 5'd1; cmd_rs2 = 5'd1; cmd_rd = 5'd22;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstcmp.feq_before", {31'b0, Feq_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstcmp.feq", {31'b0, Feq_en}, 32'd0);
    chk("rstcmp.wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rstcmp.ren", {31'b0, frf_ren}, 32'd0);
    chk("rstcmp.data", wb_data, 32'd0);
    chk("rstcmp.rd", {27'b0, wb_rd}, 32'd0);
    chk("rstcmp.rd1", read_data1, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstcmp.ready", {31'b0, cmd_ready}, 32'd1);
    wbv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      wbv_seen += int'(wb_valid);
    end
    chk("rstcmp.no_wb", wbv_seen, 32'd0);
    do_cmd("rstcmp.next", 2'b01, 5'd4, 5'd5, 5'd23, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
